// File: rtl/mem_access_if.sv
// Bundle of the execute-stage command, memory bus and completion signals of mem_access.
// The master modport is the mem_access view; the slave modport is the environment view
// (pipeline plus memory).
interface mem_access_if #(
    parameter int unsigned REGWIDTH = 32
);
    // Execute-stage command
    logic                start;
    logic                mem_read;
    logic                mem_write;
    logic [2:0]          funct3;
    logic [REGWIDTH-1:0] alu_result;
    logic [REGWIDTH-1:0] store_data;

    // Memory bus
    logic                mem_req;
    logic                mem_we;
    logic [REGWIDTH-1:0] mem_addr;
    logic [REGWIDTH-1:0] mem_wdata;
    logic [3:0]          mem_wstrb;
    logic                mem_ready;
    logic [REGWIDTH-1:0] mem_rdata;

    // Completion / status
    logic [REGWIDTH-1:0] load_data;
    logic                done;
    logic                fault;
    logic                busy;

    modport master (
        input  start, mem_read, mem_write, funct3, alu_result, store_data,
        input  mem_ready, mem_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output load_data, done, fault, busy
    );

    modport slave (
        output start, mem_read, mem_write, funct3, alu_result, store_data,
        output mem_ready, mem_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  load_data, done, fault, busy
    );
endinterface

// File: rtl/mem_access.sv
// mem_access: load/store unit sitting between the execute stage and a word-wide memory.
// Takes one command per start pulse, checks legality/alignment, issues a single held
// request, formats store data and extends load data, and reports done/fault.
module mem_access #(
    parameter int unsigned REGWIDTH = 32,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_access_if.master bus
);
    localparam int unsigned CntW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
    // Counter value in the final allowed REQ cycle (TIMEOUT >= 1 assumed).
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [REGWIDTH-1:0] addr_q, addr_d;
    logic [REGWIDTH-1:0] sdata_q, sdata_d;
    logic [2:0]          funct3_q, funct3_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic [REGWIDTH-1:0] load_data_q, load_data_d;
    logic                fault_q, fault_d;

    logic                legal_f3;
    logic                misaligned;
    logic [REGWIDTH-1:0] rdata_sh;
    logic [REGWIDTH-1:0] load_ext;
    logic [REGWIDTH-1:0] wdata_fmt;
    logic [3:0]          wstrb_fmt;
    logic                req_active;

    // Decode legality and alignment of the incoming command straight from the inputs.
    always_comb begin
        legal_f3 = 1'b0;
        if (bus.mem_write) begin
            legal_f3 = bus.funct3 inside {3'b000, 3'b001, 3'b010};
        end else begin
            legal_f3 = bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end
        // funct3[1:0] gives the access size for every legal code.
        misaligned = 1'b0;
        case (bus.funct3[1:0])
            2'b01:   misaligned = bus.alu_result[0];
            2'b10:   misaligned = |bus.alu_result[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    // Pick the addressed lane out of the read word and extend it.
    always_comb begin
        rdata_sh = bus.mem_rdata >> {addr_q[1:0], 3'b000};
        case (funct3_q)
            3'b000:  load_ext = {{(REGWIDTH - 8){rdata_sh[7]}}, rdata_sh[7:0]};
            3'b001:  load_ext = {{(REGWIDTH - 16){rdata_sh[15]}}, rdata_sh[15:0]};
            3'b100:  load_ext = {{(REGWIDTH - 8){1'b0}}, rdata_sh[7:0]};
            3'b101:  load_ext = {{(REGWIDTH - 16){1'b0}}, rdata_sh[15:0]};
            default: load_ext = bus.mem_rdata;
        endcase
    end

    // Replicate store data across lanes and build byte strobes.
    always_comb begin
        case (funct3_q[1:0])
            2'b00: begin
                wdata_fmt = {(REGWIDTH / 8){sdata_q[7:0]}};
                wstrb_fmt = 4'b0001 << addr_q[1:0];
            end
            2'b01: begin
                wdata_fmt = {(REGWIDTH / 16){sdata_q[15:0]}};
                wstrb_fmt = 4'b0011 << addr_q[1:0];
            end
            default: begin
                wdata_fmt = sdata_q;
                wstrb_fmt = 4'b1111;
            end
        endcase
    end

    // Next-state logic: command capture, request/wait/timeout and result latching.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        sdata_d     = sdata_q;
        funct3_d    = funct3_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        load_data_d = load_data_q;
        fault_d     = fault_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    addr_d   = bus.alu_result;
                    sdata_d  = bus.store_data;
                    funct3_d = bus.funct3;
                    rd_d     = bus.mem_read;
                    wr_d     = bus.mem_write;
                    cnt_d    = '0;
                    if (!bus.mem_read && !bus.mem_write) begin
                        state_d     = StDone;
                        fault_d     = 1'b0;
                        load_data_d = '0;
                    end else if ((bus.mem_read && bus.mem_write) || !legal_f3 || misaligned) begin
                        state_d     = StDone;
                        fault_d     = 1'b1;
                        load_data_d = '0;
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                if (bus.mem_ready) begin
                    state_d     = StDone;
                    fault_d     = 1'b0;
                    load_data_d = wr_q ? '0 : load_ext;
                end else if (cnt_q == CntLast) begin
                    state_d     = StDone;
                    fault_d     = 1'b1;
                    load_data_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            addr_q      <= '0;
            sdata_q     <= '0;
            funct3_q    <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            load_data_q <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            sdata_q     <= sdata_d;
            funct3_q    <= funct3_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            load_data_q <= load_data_d;
            fault_q     <= fault_d;
        end
    end

    // Bus fields are driven only while a request is outstanding, so they read 0 otherwise.
    assign req_active    = (state_q == StReq);
    assign bus.mem_req   = req_active;
    assign bus.mem_we    = req_active && wr_q;
    assign bus.mem_addr  = req_active ? {addr_q[REGWIDTH-1:2], 2'b00} : '0;
    assign bus.mem_wdata = (req_active && wr_q) ? wdata_fmt : '0;
    assign bus.mem_wstrb = (req_active && wr_q) ? wstrb_fmt : 4'b0000;
    assign bus.load_data = load_data_q;
    assign bus.fault     = fault_q;
    assign bus.done      = (state_q == StDone);
    assign bus.busy      = (state_q != StIdle);

endmodule
